// File: rtl/ldst_access_sequencer.sv
// Sequences one LDR/STR at a time over a req/ready data-memory handshake,
// stalling the pipeline until the access completes, times out, or is misaligned.
module ldst_access_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        datamem_en,
  input  logic        rw,
  input  logic        size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  rd_idx,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic        wb_en,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        fault
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCESS   = 2'd1,
    S_COMPLETE = 2'd2,
    S_FAULT    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        rw_q;
  logic        size_q;
  logic [1:0]  lane_q;
  logic [3:0]  rd_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  wb_rd_q;
  logic [31:0] wb_data_q;

  logic        misalign;
  logic        accept;
  logic [31:0] rdata_shift;
  logic [31:0] load_fmt;

  assign misalign = datamem_en & ~size & (addr[1:0] != 2'b00);
  assign accept   = (state_q == S_IDLE) & datamem_en & ~misalign;

  // Byte loads pick the addressed lane and zero-extend it.
  assign rdata_shift = mem_rdata >> {lane_q, 3'b000};
  assign load_fmt    = size_q ? {24'd0, rdata_shift[7:0]} : mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (datamem_en) begin
          if (misalign) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_ACCESS;
            cnt_d   = '0;
          end
        end
      end
      S_ACCESS: begin
        if (mem_ready) begin
          state_d = S_COMPLETE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_COMPLETE: state_d = S_IDLE;
      S_FAULT:    state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall     = accept | (state_q == S_ACCESS);
    mem_req   = (state_q == S_ACCESS);
    mem_we    = (state_q == S_ACCESS) & ~rw_q;
    mem_addr  = mem_addr_q;
    mem_be    = mem_be_q;
    mem_wdata = mem_wdata_q;
    wb_en     = (state_q == S_COMPLETE) & rw_q;
    wb_rd     = wb_rd_q;
    wb_data   = wb_data_q;
    fault     = (state_q == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rw_q        <= 1'b0;
      size_q      <= 1'b0;
      lane_q      <= 2'd0;
      rd_q        <= 4'd0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      wb_rd_q     <= 4'd0;
      wb_data_q   <= 32'd0;
    end else begin
      if (accept) begin
        rw_q        <= rw;
        size_q      <= size;
        lane_q      <= addr[1:0];
        rd_q        <= rd_idx;
        mem_addr_q  <= {addr[31:2], 2'b00};
        mem_be_q    <= (size & ~rw) ? (4'b0001 << addr[1:0]) : 4'b1111;
        mem_wdata_q <= size ? {4{wdata[7:0]}} : wdata;
      end
      // Write-back registers only move on a completing load, so they hold otherwise.
      if ((state_q == S_ACCESS) && mem_ready && rw_q) begin
        wb_rd_q   <= rd_q;
        wb_data_q <= load_fmt;
      end
    end
  end

endmodule
